// File: rtl/code_decomp_fetch.sv
// code_decomp_fetch: serves 32-bit instruction-fetch words to the cache.
// Words in the compressed code region are rebuilt from a 16-bit entry table.
// An entry indexes an on-chip dictionary, or escapes to a raw-word table.
// Addresses outside the region are forwarded unchanged to backing memory.
module code_decomp_fetch #(
  parameter logic [31:0] CODE_BASE    = 32'h0000_0000,
  parameter logic [31:0] CODE_BYTES   = 32'h0001_0000,
  parameter logic [31:0] ENTRY_BASE   = 32'h0010_0000,
  parameter logic [31:0] RAW_BASE     = 32'h0020_0000,
  parameter int          DICT_ENTRIES = 256,
  localparam int         DICT_BITS    = $clog2(DICT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_req_valid,
  output logic                 mem_req_ready,
  input  logic [31:0]          mem_req_addr,
  output logic [31:0]          mem_req_rdata,
  output logic                 back_valid,
  input  logic                 back_ready,
  output logic [31:0]          back_addr,
  input  logic [31:0]          back_rdata,
  input  logic                 dict_we,
  input  logic [DICT_BITS-1:0] dict_waddr,
  input  logic [31:0]          dict_wdata,
  output logic [31:0]          stat_dict,
  output logic [31:0]          stat_raw,
  output logic [31:0]          stat_bypass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_GAP,
    S_RAW,
    S_RESP
  } state_t;

  // Which source produced the response; selects the stat counter in RESP.
  typedef enum logic [1:0] {
    P_BYPASS,
    P_DICT,
    P_RAW
  } path_t;

  state_t      state_reg, state_next;
  path_t       path_reg, path_next;
  logic        comp_reg, comp_next;
  logic        hsel_reg, hsel_next;
  logic        abort_reg, abort_next;
  logic        back_valid_reg, back_valid_next;
  logic [31:0] back_addr_reg, back_addr_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] stat_dict_reg, stat_dict_next;
  logic [31:0] stat_raw_reg, stat_raw_next;
  logic [31:0] stat_bypass_reg, stat_bypass_next;

  logic [31:0] dict_mem [DICT_ENTRIES];

  // Request address decode: region test done in 33 bits so the upper bound
  // cannot wrap when the region ends at the top of the address space.
  logic [31:0] req_addr;
  logic [31:0] req_off;
  logic [31:0] entry_off;
  logic [31:0] entry_sum;
  logic [32:0] req_a33;
  logic [32:0] lo_a33;
  logic [32:0] hi_a33;
  logic        in_region;

  assign req_addr  = mem_req_addr & 32'hFFFF_FFFC;
  assign req_off   = req_addr - CODE_BASE;
  assign entry_off = (req_off >> 2) << 1;
  assign entry_sum = ENTRY_BASE + entry_off;
  assign req_a33   = {1'b0, req_addr};
  assign lo_a33    = {1'b0, CODE_BASE};
  assign hi_a33    = {1'b0, CODE_BASE} + {1'b0, CODE_BYTES};
  assign in_region = (req_a33 >= lo_a33) && (req_a33 < hi_a33);

  // Entry halfword selection and the two places it can point to.
  logic [15:0] entry;
  logic [31:0] dict_rd;
  logic [31:0] raw_addr;

  assign entry    = hsel_reg ? back_rdata[31:16] : back_rdata[15:0];
  assign dict_rd  = dict_mem[entry[DICT_BITS-1:0]];
  assign raw_addr = RAW_BASE + {15'd0, entry[14:0], 2'b00};

  // Dictionary write port; read is combinational so a same-cycle write is
  // not visible until the following cycle.
  always_ff @(posedge clk) begin
    if (dict_we) begin
      dict_mem[dict_waddr] <= dict_wdata;
    end
  end

  // Next-state and datapath updates for the fetch sequencer.
  always_comb begin
    state_next       = state_reg;
    path_next        = path_reg;
    comp_next        = comp_reg;
    hsel_next        = hsel_reg;
    abort_next       = abort_reg;
    back_valid_next  = back_valid_reg;
    back_addr_next   = back_addr_reg;
    rdata_next       = rdata_reg;
    stat_dict_next   = stat_dict_reg;
    stat_raw_next    = stat_raw_reg;
    stat_bypass_next = stat_bypass_reg;

    case (state_reg)
      S_IDLE: begin
        if (mem_req_valid) begin
          if (in_region) begin
            back_addr_next = entry_sum & 32'hFFFF_FFFC;
            hsel_next      = entry_sum[1];
            comp_next      = 1'b1;
          end else begin
            back_addr_next = req_addr;
            hsel_next      = 1'b0;
            comp_next      = 1'b0;
          end
          back_valid_next = 1'b1;
          state_next      = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (!mem_req_valid) begin
          abort_next = 1'b1;
        end
        if (back_ready) begin
          back_valid_next = 1'b0;
          if (!comp_reg) begin
            rdata_next = back_rdata;
            path_next  = P_BYPASS;
            state_next = S_RESP;
          end else if (!entry[15]) begin
            rdata_next = dict_rd;
            path_next  = P_DICT;
            state_next = S_RESP;
          end else begin
            back_addr_next = raw_addr;
            path_next      = P_RAW;
            state_next     = S_GAP;
          end
        end
      end

      // One idle cycle between the entry fetch and the raw-word fetch.
      S_GAP: begin
        if (!mem_req_valid) begin
          abort_next = 1'b1;
        end
        back_valid_next = 1'b1;
        state_next      = S_RAW;
      end

      S_RAW: begin
        if (!mem_req_valid) begin
          abort_next = 1'b1;
        end
        if (back_ready) begin
          rdata_next      = back_rdata;
          back_valid_next = 1'b0;
          state_next      = S_RESP;
        end
      end

      S_RESP: begin
        if (!abort_reg) begin
          case (path_reg)
            P_DICT:   stat_dict_next   = stat_dict_reg + 32'd1;
            P_RAW:    stat_raw_next    = stat_raw_reg + 32'd1;
            default:  stat_bypass_next = stat_bypass_reg + 32'd1;
          endcase
        end
        abort_next = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= S_IDLE;
      path_reg        <= P_BYPASS;
      comp_reg        <= 1'b0;
      hsel_reg        <= 1'b0;
      abort_reg       <= 1'b0;
      back_valid_reg  <= 1'b0;
      back_addr_reg   <= 32'd0;
      rdata_reg       <= 32'd0;
      stat_dict_reg   <= 32'd0;
      stat_raw_reg    <= 32'd0;
      stat_bypass_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      path_reg        <= path_next;
      comp_reg        <= comp_next;
      hsel_reg        <= hsel_next;
      abort_reg       <= abort_next;
      back_valid_reg  <= back_valid_next;
      back_addr_reg   <= back_addr_next;
      rdata_reg       <= rdata_next;
      stat_dict_reg   <= stat_dict_next;
      stat_raw_reg    <= stat_raw_next;
      stat_bypass_reg <= stat_bypass_next;
    end
  end

  assign mem_req_ready = (state_reg == S_RESP) && !abort_reg;
  assign mem_req_rdata = rdata_reg;
  assign back_valid    = back_valid_reg;
  assign back_addr     = back_addr_reg;
  assign stat_dict     = stat_dict_reg;
  assign stat_raw      = stat_raw_reg;
  assign stat_bypass   = stat_bypass_reg;

endmodule

// File: tb/tb_code_decomp_fetch.sv
// Directed bench for code_decomp_fetch: a backing-memory responder with a
// programmable delay, and one task per scenario checking its own results.
module tb_code_decomp_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        back_valid;
  logic        back_ready;
  logic [31:0] back_addr;
  logic [31:0] back_rdata;
  logic        dict_we;
  logic [7:0]  dict_waddr;
  logic [31:0] dict_wdata;
  logic [31:0] stat_dict;
  logic [31:0] stat_raw;
  logic [31:0] stat_bypass;

  code_decomp_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_rdata(mem_req_rdata),
    .back_valid   (back_valid),
    .back_ready   (back_ready),
    .back_addr    (back_addr),
    .back_rdata   (back_rdata),
    .dict_we      (dict_we),
    .dict_waddr   (dict_waddr),
    .dict_wdata   (dict_wdata),
    .stat_dict    (stat_dict),
    .stat_raw     (stat_raw),
    .stat_bypass  (stat_bypass)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int resp_delay = 0;
  int bk_cnt = 0;
  int ready_cnt = 0;

  logic [31:0] bmem [logic [31:0]];
  logic        bv_tr [0:63];
  logic [31:0] ba_tr [0:63];

  function automatic logic [31:0] bk_lookup(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Backing memory: answers resp_delay cycles after back_valid is first seen.
  initial begin
    back_ready = 1'b0;
    back_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (back_valid === 1'b1 && back_ready === 1'b0) begin
        if (bk_cnt >= resp_delay) begin
          back_ready = 1'b1;
          back_rdata = bk_lookup(back_addr);
          bk_cnt = 0;
        end else begin
          bk_cnt++;
        end
      end else begin
        back_ready = 1'b0;
        back_rdata = 32'd0;
        bk_cnt = 0;
      end
    end
  end

  // Counts every ready pulse the cache would see.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_ready === 1'b1) ready_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic dict_write(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    dict_we = 1'b1;
    dict_waddr = idx;
    dict_wdata = val;
    @(negedge clk);
    dict_we = 1'b0;
  endtask

  // Issues one request; records back_valid/back_addr per cycle after accept.
  task automatic do_req(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    for (int i = 0; i < 64; i++) begin
      bv_tr[i] = 1'b0;
      ba_tr[i] = 32'd0;
    end
    lat = -1;
    rdata = 32'd0;
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr = addr;
    @(posedge clk);
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      bv_tr[c] = back_valid;
      ba_tr[c] = back_addr;
      if (mem_req_ready === 1'b1) begin
        lat = c;
        rdata = mem_req_rdata;
        break;
      end
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (mem_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", mem_req_ready); end
    total++; if (mem_req_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", mem_req_rdata); end
    total++; if (back_valid !== 1'b0) begin bad++; $display("FAIL reset_back_valid: got %b want 0", back_valid); end
    total++; if (back_addr !== 32'd0) begin bad++; $display("FAIL reset_back_addr: got %h want 0", back_addr); end
    total++; if ({stat_dict, stat_raw, stat_bypass} !== 96'd0) begin bad++; $display("FAIL reset_stats: got %h %h %h want 0", stat_dict, stat_raw, stat_bypass); end
    $display("reset: ready=%b rdata=%h back_valid=%b", mem_req_ready, mem_req_rdata, back_valid);
  endtask

  task automatic test_dict_hit();
    logic [31:0] r;
    int lat;
    dict_write(8'd5, 32'hDEADBEEF);
    bmem[32'h0010_0000] = 32'h8000_0005;
    do_req(32'h0, r, lat);
    @(negedge clk);
    $display("dict_hit: addr=00000000 rdata=%h lat=%0d", r, lat);
    total++; if (ba_tr[1] !== 32'h0010_0000 || bv_tr[1] !== 1'b1) begin bad++; $display("FAIL dict_back_addr: got %h/%b want 00100000/1", ba_tr[1], bv_tr[1]); end
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL dict_rdata: got %h want deadbeef", r); end
    total++; if (lat !== 2) begin bad++; $display("FAIL dict_latency: got %0d want 2", lat); end
    total++; if (stat_dict !== 32'd1 || stat_raw !== 32'd0 || stat_bypass !== 32'd0) begin bad++; $display("FAIL dict_stats: got %0d %0d %0d want 1 0 0", stat_dict, stat_raw, stat_bypass); end
  endtask

  task automatic test_raw();
    logic [31:0] r;
    int lat;
    bmem[32'h0010_0000] = 32'h8003_0005;
    bmem[32'h0020_000C] = 32'h1234_5678;
    do_req(32'h4, r, lat);
    @(negedge clk);
    $display("raw: addr=00000004 rdata=%h lat=%0d", r, lat);
    total++; if (ba_tr[1] !== 32'h0010_0000) begin bad++; $display("FAIL raw_entry_addr: got %h want 00100000", ba_tr[1]); end
    total++; if (bv_tr[2] !== 1'b0) begin bad++; $display("FAIL raw_gap: got back_valid=%b want 0", bv_tr[2]); end
    total++; if (bv_tr[3] !== 1'b1 || ba_tr[3] !== 32'h0020_000C) begin bad++; $display("FAIL raw_back_addr: got %h/%b want 0020000c/1", ba_tr[3], bv_tr[3]); end
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL raw_rdata: got %h want 12345678", r); end
    total++; if (lat !== 4) begin bad++; $display("FAIL raw_latency: got %0d want 4", lat); end
    total++; if (stat_raw !== 32'd1 || stat_dict !== 32'd1) begin bad++; $display("FAIL raw_stats: got raw=%0d dict=%0d want 1 1", stat_raw, stat_dict); end
  endtask

  task automatic test_bypass();
    logic [31:0] r;
    int lat;
    bmem[32'h0001_0000] = 32'hA5A5_0001;
    do_req(32'h0001_0000, r, lat);
    @(negedge clk);
    $display("bypass: addr=00010000 rdata=%h lat=%0d", r, lat);
    total++; if (ba_tr[1] !== 32'h0001_0000) begin bad++; $display("FAIL bypass_addr: got %h want 00010000", ba_tr[1]); end
    total++; if (r !== 32'hA5A5_0001) begin bad++; $display("FAIL bypass_rdata: got %h want a5a50001", r); end
    total++; if (lat !== 2) begin bad++; $display("FAIL bypass_latency: got %0d want 2", lat); end
    total++; if (stat_bypass !== 32'd1) begin bad++; $display("FAIL bypass_stat: got %0d want 1", stat_bypass); end

    dict_write(8'd7, 32'hCAFE_F00D);
    bmem[32'h0010_7FFC] = 32'h0007_1111;
    do_req(32'h0000_FFFC, r, lat);
    @(negedge clk);
    $display("last_word: addr=0000fffc rdata=%h lat=%0d", r, lat);
    total++; if (ba_tr[1] !== 32'h0010_7FFC) begin bad++; $display("FAIL last_word_addr: got %h want 00107ffc", ba_tr[1]); end
    total++; if (r !== 32'hCAFE_F00D) begin bad++; $display("FAIL last_word_rdata: got %h want cafef00d", r); end
    total++; if (stat_dict !== 32'd2 || stat_bypass !== 32'd1) begin bad++; $display("FAIL last_word_stats: got dict=%0d bypass=%0d want 2 1", stat_dict, stat_bypass); end

    // Low address bits ignored, and dictionary index upper bits ignored.
    bmem[32'h0010_0004] = 32'h0000_0105;
    do_req(32'h0000_000B, r, lat);
    @(negedge clk);
    $display("idx_wrap: addr=0000000b rdata=%h lat=%0d", r, lat);
    total++; if (ba_tr[1] !== 32'h0010_0004) begin bad++; $display("FAIL idx_wrap_addr: got %h want 00100004", ba_tr[1]); end
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL idx_wrap_rdata: got %h want deadbeef", r); end
    total++; if (stat_dict !== 32'd3) begin bad++; $display("FAIL idx_wrap_stat: got %0d want 3", stat_dict); end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int lat;
    int rc;
    rc = ready_cnt;
    resp_delay = 3;
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    mem_req_valid = 1'b0;
    repeat (12) @(negedge clk);
    $display("abort: pulses=%0d stats=%0d/%0d/%0d", ready_cnt - rc, stat_dict, stat_raw, stat_bypass);
    total++; if (ready_cnt !== rc) begin bad++; $display("FAIL abort_pulse: got %0d pulses want 0", ready_cnt - rc); end
    total++; if (stat_dict !== 32'd3 || stat_raw !== 32'd1 || stat_bypass !== 32'd1) begin bad++; $display("FAIL abort_stats: got %0d %0d %0d want 3 1 1", stat_dict, stat_raw, stat_bypass); end
    total++; if (back_valid !== 1'b0) begin bad++; $display("FAIL abort_back_valid: got %b want 0", back_valid); end
    resp_delay = 0;
    do_req(32'h0, r, lat);
    @(negedge clk);
    $display("after_abort: rdata=%h lat=%0d", r, lat);
    total++; if (r !== 32'hDEADBEEF || lat !== 2) begin bad++; $display("FAIL after_abort: got %h lat %0d want deadbeef lat 2", r, lat); end
    total++; if (stat_dict !== 32'd4) begin bad++; $display("FAIL after_abort_stat: got %0d want 4", stat_dict); end
  endtask

  task automatic test_stall();
    logic [31:0] r;
    int lat;
    int rc;
    rc = ready_cnt;
    resp_delay = 5;
    do_req(32'h0, r, lat);
    resp_delay = 0;
    for (int c = 1; c <= 6; c++) begin
      total++; if (bv_tr[c] !== 1'b1 || ba_tr[c] !== 32'h0010_0000) begin bad++; $display("FAIL stall_hold[%0d]: got %h/%b want 00100000/1", c, ba_tr[c], bv_tr[c]); end
    end
    repeat (3) @(negedge clk);
    $display("stall: rdata=%h lat=%0d pulses=%0d", r, lat, ready_cnt - rc);
    total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_rdata: got %h want deadbeef", r); end
    total++; if (lat !== 7) begin bad++; $display("FAIL stall_latency: got %0d want 7", lat); end
    total++; if (ready_cnt - rc !== 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", ready_cnt - rc); end
    total++; if (stat_dict !== 32'd5) begin bad++; $display("FAIL stall_stat: got %0d want 5", stat_dict); end
  endtask

  task automatic test_reset_in_raw();
    logic [31:0] r;
    int lat;
    resp_delay = 3;
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr = 32'h4;
    @(posedge clk);
    repeat (7) @(negedge clk);
    total++; if (back_valid !== 1'b1 || back_addr !== 32'h0020_000C) begin bad++; $display("FAIL rst_raw_reached: got %h/%b want 0020000c/1", back_addr, back_valid); end
    #2;
    resetn = 1'b0;
    #1;
    $display("reset_in_raw: back_valid=%b back_addr=%h rdata=%h", back_valid, back_addr, mem_req_rdata);
    total++; if (back_valid !== 1'b0 || back_addr !== 32'd0) begin bad++; $display("FAIL rst_raw_back: got %h/%b want 0/0", back_addr, back_valid); end
    total++; if (mem_req_rdata !== 32'd0 || mem_req_ready !== 1'b0) begin bad++; $display("FAIL rst_raw_resp: got %h/%b want 0/0", mem_req_rdata, mem_req_ready); end
    total++; if ({stat_dict, stat_raw, stat_bypass} !== 96'd0) begin bad++; $display("FAIL rst_raw_stats: got %0d %0d %0d want 0", stat_dict, stat_raw, stat_bypass); end
    mem_req_valid = 1'b0;
    resp_delay = 0;
    @(negedge clk);
    resetn = 1'b1;
    do_req(32'h0, r, lat);
    @(negedge clk);
    $display("post_reset: rdata=%h lat=%0d", r, lat);
    total++; if (r !== 32'hDEADBEEF || lat !== 2) begin bad++; $display("FAIL post_reset: got %h lat %0d want deadbeef lat 2", r, lat); end
    total++; if (stat_dict !== 32'd1) begin bad++; $display("FAIL post_reset_stat: got %0d want 1", stat_dict); end
  endtask

  initial begin
    resetn = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr = 32'd0;
    dict_we = 1'b0;
    dict_waddr = 8'd0;
    dict_wdata = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_dict_hit();
    test_raw();
    test_bypass();
    test_abort();
    test_stall();
    test_reset_in_raw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
